// File: rtl/axi_rd_arb2.sv
// axi_rd_arb2 -- two-master AXI read arbiter.
//
// Shares one slave AR channel between master 0 and master 1 using round-robin.
// The grant order is recorded in a small order FIFO, and the in-order R beats
// coming back from the slave are steered to the master at the FIFO head. A
// burst changes owner only after its rlast beat is accepted.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   mN_ar*  (N=0,1)         master N read-address channel (in; arready out)
//   s_ar*                   registered read-address channel to the slave
//   s_r*                    read-data channel from the slave (rready out)
//   mN_r*   (N=0,1)         read-data channel to master N (rready in)
//   outst_cnt               bursts issued whose rlast has not yet been accepted
//   unexp_r                 sticky: an R beat arrived with nothing outstanding
module axi_rd_arb2 #(
    parameter int ID_WID    = 8,
    parameter int ADDR_WID  = 32,
    parameter int DATA_WID  = 32,
    parameter int USER_WID  = 2,
    parameter int MAX_OUTST = 8,
    parameter int CNT_WID   = 4
) (
    input  logic                clk,
    input  logic                reset,
    // master 0 AR
    input  logic [ID_WID-1:0]   m0_arid,
    input  logic [ADDR_WID-1:0] m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [USER_WID-1:0] m0_aruser,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    // master 1 AR
    input  logic [ID_WID-1:0]   m1_arid,
    input  logic [ADDR_WID-1:0] m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [USER_WID-1:0] m1_aruser,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    // slave AR
    output logic [ID_WID-1:0]   s_arid,
    output logic [ADDR_WID-1:0] s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [USER_WID-1:0] s_aruser,
    output logic                s_arvalid,
    input  logic                s_arready,
    // slave R
    input  logic [ID_WID-1:0]   s_rid,
    input  logic [DATA_WID-1:0] s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic [USER_WID-1:0] s_ruser,
    input  logic                s_rlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    // master 0 R
    output logic [ID_WID-1:0]   m0_rid,
    output logic [DATA_WID-1:0] m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic [USER_WID-1:0] m0_ruser,
    output logic                m0_rlast,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    // master 1 R
    output logic [ID_WID-1:0]   m1_rid,
    output logic [DATA_WID-1:0] m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic [USER_WID-1:0] m1_ruser,
    output logic                m1_rlast,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    // status
    output logic [CNT_WID-1:0]  outst_cnt,
    output logic                unexp_r
);

    localparam int PTR_W = CNT_WID - 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]          r_state;
    logic                r_last_grant;
    logic [ID_WID-1:0]   r_arid;
    logic [ADDR_WID-1:0] r_araddr;
    logic [7:0]          r_arlen;
    logic [2:0]          r_arsize;
    logic [USER_WID-1:0] r_aruser;
    logic                r_arvalid;
    logic [CNT_WID-1:0]  r_outst_cnt;
    logic                r_unexp_r;
    logic [MAX_OUTST-1:0] r_ord_mem;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;

    logic w_cap_ok;
    logic w_gnt_vld;
    logic w_gnt_idx;
    logic w_ar_hs;
    logic w_ord_empty;
    logic w_head;
    logic w_head_rready;
    logic w_pop;

    // The order FIFO holds exactly one entry per outstanding burst, so its
    // occupancy is outst_cnt itself; no separate fill counter is kept.
    assign w_ord_empty = (r_outst_cnt == '0);
    assign w_cap_ok    = (r_outst_cnt < CNT_WID'(MAX_OUTST));

    // Both requesting: the master that did not win last time gets the grant.
    assign w_gnt_idx = (m0_arvalid && m1_arvalid) ? ~r_last_grant : m1_arvalid;
    assign w_gnt_vld = (r_state == ST_IDLE) && w_cap_ok && (m0_arvalid || m1_arvalid);

    assign m0_arready = w_gnt_vld && (w_gnt_idx == 1'b0);
    assign m1_arready = w_gnt_vld && (w_gnt_idx == 1'b1);

    assign w_ar_hs = r_arvalid && s_arready;

    assign s_arid    = r_arid;
    assign s_araddr  = r_araddr;
    assign s_arlen   = r_arlen;
    assign s_arsize  = r_arsize;
    assign s_aruser  = r_aruser;
    assign s_arvalid = r_arvalid;
    assign outst_cnt = r_outst_cnt;
    assign unexp_r   = r_unexp_r;

    // R path: data is broadcast, only the head owner sees rvalid.
    assign w_head        = r_ord_mem[r_rd_ptr];
    assign w_head_rready = w_head ? m1_rready : m0_rready;
    assign s_rready      = ~w_ord_empty && w_head_rready;
    assign w_pop         = s_rvalid && s_rready && s_rlast;

    assign m0_rvalid = s_rvalid && ~w_ord_empty && (w_head == 1'b0);
    assign m1_rvalid = s_rvalid && ~w_ord_empty && (w_head == 1'b1);

    assign m0_rid   = s_rid;
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_ruser = s_ruser;
    assign m0_rlast = s_rlast;
    assign m1_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_ruser = s_ruser;
    assign m1_rlast = s_rlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_aruser     <= '0;
            r_arvalid    <= 1'b0;
            r_outst_cnt  <= '0;
            r_unexp_r    <= 1'b0;
            r_ord_mem    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_arid       <= w_gnt_idx ? m1_arid   : m0_arid;
                        r_araddr     <= w_gnt_idx ? m1_araddr : m0_araddr;
                        r_arlen      <= w_gnt_idx ? m1_arlen  : m0_arlen;
                        r_arsize     <= w_gnt_idx ? m1_arsize : m0_arsize;
                        r_aruser     <= w_gnt_idx ? m1_aruser : m0_aruser;
                        r_arvalid    <= 1'b1;
                        r_last_grant <= w_gnt_idx;
                        r_state      <= ST_ISSUE;
                    end
                end
                default: begin
                    // r_last_grant cannot change until this AR is accepted,
                    // so it also names the owner of the burst being issued.
                    if (w_ar_hs) begin
                        r_ord_mem[r_wr_ptr] <= r_last_grant;
                        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                        r_arvalid           <= 1'b0;
                        r_state             <= ST_IDLE;
                    end
                end
            endcase

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_ar_hs, w_pop})
                2'b10:   r_outst_cnt <= r_outst_cnt + CNT_WID'(1);
                2'b01:   r_outst_cnt <= r_outst_cnt - CNT_WID'(1);
                default: r_outst_cnt <= r_outst_cnt;
            endcase

            if (s_rvalid && w_ord_empty) begin
                r_unexp_r <= 1'b1;
            end
        end
    end

endmodule
